wb_port_arbiter: RTL
====================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 FIFO_DEPTH, 2, number of buffered multi-cycle write requests (power of two, >=2).
REQ-002 STARVE_LIMIT, 4, consecutive blocked cycles allowed for the FIFO head before WB is stalled.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 wb_valid  input  1  WB stage presents a register write this cycle.
REQ-007 wb_waddr  input  5  WB destination register.
REQ-008 wb_wdata  input  64  WB write data.
REQ-009 mc_valid  input  1  multi-cycle unit offers a result.
REQ-010 mc_ready  output  1  arbiter can accept an mc result.
REQ-011 mc_waddr  input  5  mc destination register.
REQ-012 mc_wdata  input  64  mc write data.
REQ-013 wb_stall  output  1  WB stage must hold its write this cycle.
REQ-014 rf_we  output  1  register-file write enable.
REQ-015 rf_waddr  output  5  register-file write address.
REQ-016 rf_wdata  output  64  register-file write data.
REQ-017 mc_pending  output  1  at least one valid entry queued.

Function
REQ-018 mc handshake completes when mc_valid && mc_ready; mc_ready = !reset && (count < FIFO_DEPTH), from registered count only (no same-cycle pop pass-through).
REQ-019 Accepted mc write to register 31 (XZR) is discarded, not enqueued; WB write to 31 is never granted.
REQ-020 Each FIFO entry holds {valid, waddr, wdata}; enqueued entry is eligible for grant no earlier than the next cycle.
REQ-021 State ARB_NORMAL: grant WB if wb_valid and wb_waddr != 31; else grant FIFO head if count > 0; else no grant.
REQ-022 State ARB_FORCE_MC: wb_stall = 1, wb_valid ignored, FIFO head granted; next state ARB_NORMAL unconditionally.
REQ-023 wb_stall is combinational from state and is 0 in ARB_NORMAL.
REQ-024 Granted write appears on rf_* one cycle later (registered); rf_we = 0 in cycles following no grant.
REQ-025 Granting the FIFO head pops it; a popped entry with valid = 0 produces rf_we = 0.
REQ-026 Starve counter increments each cycle count > 0 and head not granted; cleared on pop or when empty.
REQ-027 When counter reaches STARVE_LIMIT, next state is ARB_FORCE_MC and counter clears.
REQ-028 A granted WB write to address A clears valid on every queued entry with waddr A, including an entry enqueued in the same cycle; WB writes are younger than all queued mc writes.
REQ-029 Pointers wrap modulo FIFO_DEPTH; simultaneous enqueue and pop leave count unchanged.
REQ-030 mc_pending = OR of valid bits of occupied entries.

Reset
REQ-031 On reset: rf_we = 0, rf_waddr = 0, rf_wdata = 0, wb_stall = 0, mc_ready = 0, mc_pending = 0, count = 0, pointers = 0, starve counter = 0, state ARB_NORMAL.
REQ-032 Reset mid-operation discards all queued writes; none reaches rf_* after release.

Structure
REQ-033 Package wb_arb_pkg holds the state enum (ARB_NORMAL, ARB_FORCE_MC), XZR_ADDR = 5'd31, and the write-request struct {valid, waddr[4:0], wdata[63:0]}.
REQ-034 Sub-module wb_arb_fifo implements the circular buffer with per-entry valid and address-match squash; arbitration, FSM, and output registers stay in wb_port_arbiter.

Verification
REQ-035 Reset with 2 entries queued -> rf_we = 0, mc_pending = 0, mc_ready = 0; after release mc_ready = 1, no stale write.
REQ-036 WB addr 5, data 0xDEAD at cycle t -> rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEAD at t+1.
REQ-037 Idle WB, mc addr 7, data 0x1234 accepted at t -> rf_we = 1, rf_waddr = 7 at t+2.
REQ-038 WB continuously writing addr 1, one mc entry addr 9 queued at t -> blocked t+1..t+4, wb_stall = 1 at t+5, rf_waddr = 9 at t+6, WB resumes at t+6.
REQ-039 mc entry addr 3 queued, WB writes addr 3 data 0xAA -> rf_wdata = 0xAA; later head pop gives rf_we = 0; register 3 ends 0xAA.
REQ-040 WB write to addr 31 -> rf_we = 0; 2 mc entries queued while WB busy -> mc_ready = 0, third mc_valid held.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback port arbiter: FSM states, the XZR address
// and the write-request record held in the multi-cycle queue.
package wb_arb_pkg;

  localparam logic [4:0] XZR_ADDR = 5'd31;

  typedef enum logic {
    ARB_NORMAL   = 1'b0,
    ARB_FORCE_MC = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  waddr;
    logic [63:0] wdata;
  } wr_req_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// Circular buffer of multi-cycle write requests. Each entry carries its own
// valid bit so a younger WB write can squash queued writes to the same register.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  wr_req_t       push_req,
  input  logic          pop,
  input  logic          squash_en,
  input  logic [4:0]    squash_addr,
  output wr_req_t       head,
  output logic [CW-1:0] count,
  output logic          any_valid
);

  wr_req_t       mem_q [DEPTH];
  wr_req_t       mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (squash_en && (mem_q[i].waddr == squash_addr)) mem_d[i].valid = 1'b0;
    end

    // Popped slots are left invalid so any_valid only ever sees occupied entries.
    if (pop) begin
      mem_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d              = rd_ptr_q + PW'(1);
    end

    if (push) begin
      mem_d[wr_ptr_q] = push_req;
      if (squash_en && (push_req.waddr == squash_addr)) mem_d[wr_ptr_q].valid = 1'b0;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | mem_q[i].valid;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the WB stage and a queue
// of multi-cycle results; WB has priority until the queue head starves.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_waddr,
  input  logic [63:0] wb_wdata,
  input  logic        mc_valid,
  output logic        mc_ready,
  input  logic [4:0]  mc_waddr,
  input  logic [63:0] mc_wdata,
  output logic        wb_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic        mc_pending,
  output arb_state_e  dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [SW-1:0] starve_inc;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [63:0]   rf_wdata_q, rf_wdata_d;

  logic          grant_wb, grant_mc;
  logic          fifo_push;
  wr_req_t       push_req;
  wr_req_t       head;
  logic [CW-1:0] fifo_count;
  logic          fifo_any_valid;

  // Handshake: an mc result transfers on any cycle where mc_valid && mc_ready;
  // mc_ready looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign mc_ready  = !reset && (fifo_count < CW'(FIFO_DEPTH));
  assign fifo_push = mc_valid && mc_ready && (mc_waddr != XZR_ADDR);
  assign push_req  = '{valid: 1'b1, waddr: mc_waddr, wdata: mc_wdata};

  wb_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (fifo_push),
    .push_req    (push_req),
    .pop         (grant_mc),
    .squash_en   (grant_wb),
    .squash_addr (wb_waddr),
    .head        (head),
    .count       (fifo_count),
    .any_valid   (fifo_any_valid)
  );

  assign starve_inc = starve_q + SW'(1);

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    grant_wb   = 1'b0;
    grant_mc   = 1'b0;
    wb_stall   = 1'b0;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    case (state_q)
      ARB_NORMAL: begin
        grant_wb = wb_valid && (wb_waddr != XZR_ADDR);
        grant_mc = !grant_wb && (fifo_count != '0);
      end
      ARB_FORCE_MC: begin
        wb_stall = 1'b1;
        grant_mc = (fifo_count != '0);
        state_d  = ARB_NORMAL;
      end
      default: state_d = ARB_NORMAL;
    endcase

    if ((fifo_count == '0) || grant_mc) begin
      starve_d = '0;
    end else if (starve_inc == SW'(STARVE_LIMIT)) begin
      starve_d = '0;
      state_d  = ARB_FORCE_MC;
    end else begin
      starve_d = starve_inc;
    end

    // A squashed head still pops, but leaves the port idle for that cycle.
    if (grant_wb) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb_waddr;
      rf_wdata_d = wb_wdata;
    end else if (grant_mc) begin
      rf_we_d    = head.valid;
      rf_waddr_d = head.waddr;
      rf_wdata_d = head.wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_NORMAL;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign mc_pending = fifo_any_valid;
  assign dbg_state  = state_q;

endmodule
